// File: rtl/hello_count_sequencer_pkg.sv
// Shared types and segment encodings for the HELLO scroller / seconds counter.
// Segment patterns are gfedcba with 1 = lit.
package hello_count_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StScroll = 2'd1,
    StCount  = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_H     = 7'b1110110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_L     = 7'b0111000;
  localparam logic [6:0] SEG_O     = 7'b0111111;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  localparam int unsigned SCROLL_LEN = 6;
  localparam logic [6:0] SCROLL_SEQ [SCROLL_LEN] = '{
    SEG_H, SEG_E, SEG_L, SEG_L, SEG_O, SEG_BLANK
  };

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_DIGIT[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/hello_count_sequencer_tick_gen.sv
// Free-running tick divider; tick is a registered flag that is high exactly while the
// counter holds TICK_DIV-1, so it freezes together with the counter when en drops.
module hello_count_sequencer_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic sync_clear,
  output logic tick
);

  localparam int unsigned W = $clog2(TICK_DIV);
  localparam logic [W-1:0] CNT_LAST = W'(TICK_DIV - 1);
  localparam logic [W-1:0] CNT_PRE  = W'(TICK_DIV - 2);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = tick_q;
    if (sync_clear) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end else if (en) begin
      cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + W'(1);
      tick_d = (cnt_q == CNT_PRE);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/hello_count_sequencer.sv
// Six-digit display controller: scrolls HELLO, counts BCD seconds to COUNT_MAX, then blinks.
// All digit, state and tick outputs come straight from flops.
module hello_count_sequencer
  import hello_count_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned SCROLL_STEPS = 10,
  parameter int unsigned COUNT_MAX    = 59
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic       pause,
  output logic       tick_o,
  output logic [1:0] state_o,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  localparam logic [7:0] STEPS_LAST = 8'(SCROLL_STEPS - 1);
  localparam logic [3:0] MAX_TENS   = 4'(COUNT_MAX / 10);
  localparam logic [3:0] MAX_ONES   = 4'(COUNT_MAX % 10);

  state_e     state_q, state_d;
  logic [6:0] hex_q [6];
  logic [6:0] hex_d [6];
  logic [7:0] step_q, step_d;
  logic [2:0] chr_q, chr_d;
  logic [3:0] ones_q, ones_d, tens_q, tens_d;
  logic [3:0] ones_inc, tens_inc;
  logic       blink_q, blink_d;
  logic       tick;

  hello_count_sequencer_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk       (clk),
    .clr       (clr),
    .en        (run & ~pause),
    .sync_clear(~run),
    .tick      (tick)
  );

  always_comb begin
    if (ones_q == 4'd9) begin
      ones_inc = 4'd0;
      tens_inc = tens_q + 4'd1;
    end else begin
      ones_inc = ones_q + 4'd1;
      tens_inc = tens_q;
    end
  end

  always_comb begin
    state_d = state_q;
    hex_d   = hex_q;
    step_d  = step_q;
    chr_d   = chr_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    blink_d = blink_q;
    if (!run) begin
      state_d = StIdle;
      hex_d   = '{default: SEG_BLANK};
      step_d  = '0;
      chr_d   = '0;
      ones_d  = '0;
      tens_d  = '0;
      blink_d = 1'b1;
    end else if (!pause) begin
      case (state_q)
        StIdle: state_d = StScroll;
        StScroll: begin
          if (tick) begin
            if (step_q == STEPS_LAST) begin
              // The final scroll tick lands directly on 00 instead of shifting.
              state_d  = StCount;
              hex_d    = '{default: SEG_BLANK};
              hex_d[0] = SEG_DIGIT[0];
              hex_d[1] = SEG_DIGIT[0];
              ones_d   = '0;
              tens_d   = '0;
              blink_d  = 1'b1;
            end else begin
              for (int i = 5; i > 0; i--) hex_d[i] = hex_q[i-1];
              hex_d[0] = SCROLL_SEQ[chr_q];
              chr_d    = (chr_q == 3'(SCROLL_LEN - 1)) ? 3'd0 : chr_q + 3'd1;
              step_d   = step_q + 8'd1;
            end
          end
        end
        StCount: begin
          if (tick) begin
            ones_d   = ones_inc;
            tens_d   = tens_inc;
            hex_d[0] = digit_seg(ones_inc);
            hex_d[1] = digit_seg(tens_inc);
            if (tens_inc == MAX_TENS && ones_inc == MAX_ONES) state_d = StDone;
          end
        end
        StDone: begin
          if (tick) begin
            blink_d  = ~blink_q;
            hex_d[0] = blink_q ? SEG_BLANK : digit_seg(ones_q);
            hex_d[1] = blink_q ? SEG_BLANK : digit_seg(tens_q);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      hex_q   <= '{default: SEG_BLANK};
      step_q  <= '0;
      chr_q   <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
      blink_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hex_q   <= hex_d;
      step_q  <= step_d;
      chr_q   <= chr_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      blink_q <= blink_d;
    end
  end

  assign tick_o  = tick;
  assign state_o = state_q;
  assign HEX0    = hex_q[0];
  assign HEX1    = hex_q[1];
  assign HEX2    = hex_q[2];
  assign HEX3    = hex_q[3];
  assign HEX4    = hex_q[4];
  assign HEX5    = hex_q[5];

endmodule
